// File: rtl/riscv_mem_pkg.sv
// Shared load/store definitions for the data-memory path:
// funct3 codes, responder state encoding and load extension.
package riscv_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      RESP
   } dmem_state_e;

   function automatic logic [31:0] load_extend(
      input logic [31:0] word,
      input logic [2:0]  f3,
      input logic [1:0]  off
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      r = '0;
      case (f3)
         F3_LB:   r = {{24{b[7]}}, b};
         F3_LBU:  r = {24'h0, b};
         F3_LH:   r = {{16{h[15]}}, h};
         F3_LHU:  r = {16'h0, h};
         F3_LW:   r = word;
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage with byte-lane write enables
// and a registered read port; contents are never reset.
module dmem_array
   import riscv_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [AW-1:0] idx_i,
   input  logic [3:0]    be_i,
   input  logic [31:0]   wdata_i,
   input  logic          re_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (be_i[i]) begin
            mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store target for the MEM stage: wait states, RV32I access, response.
// Define DMEM_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module dmem_responder
   import riscv_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT =
      CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

   dmem_state_e state_q, state_d;
   logic          rdy_q;
   logic          we_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [2:0]    f3_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;

   logic          acc_hs;
   logic          oor, bad_f3, mis, err_a;
   logic [3:0]    be;
   logic [31:0]   wlane;
   logic          re;
   logic [31:0]   arr_rdata;

   assign req_ready = rdy_q && (state_q == IDLE);
   assign acc_hs    = req_valid && req_ready;
   assign busy      = (state_q != IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   assign oor = ({1'b0, addr_q} >= ADDR_LIMIT);

   always_comb begin
      if (we_q) begin
         bad_f3 = (f3_q > F3_SW);
      end else begin
         bad_f3 = (f3_q == 3'd3) || (f3_q == 3'd6) || (f3_q == 3'd7);
      end
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   always_comb begin
      case (f3_q)
         F3_LH, F3_LHU: mis = addr_q[0];
         F3_LW:         mis = |addr_q[1:0];
         default:       mis = 1'b0;
      endcase
   end
`else
   assign mis = 1'b0;
`endif

   assign err_a = oor | bad_f3 | mis;

   // Store data is replicated so each lane sees its own byte.
   always_comb begin
      be    = 4'b0000;
      wlane = wdata_q;
      case (f3_q[1:0])
         2'd0: begin
            be    = 4'b0001 << addr_q[1:0];
            wlane = {4{wdata_q[7:0]}};
         end
         2'd1: begin
            be    = addr_q[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata_q[15:0]}};
         end
         default: be = 4'b1111;
      endcase
      if (!(state_q == ACCESS && we_q && !err_a)) begin
         be = 4'b0000;
      end
   end

   assign re = (state_q == ACCESS) && !we_q && !err_a;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk     (clk),
      .idx_i   (addr_q[2 +: AW]),
      .be_i    (be),
      .wdata_i (wlane),
      .re_i    (re),
      .rdata_o (arr_rdata)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      unique case (state_q)
         IDLE: begin
            if (acc_hs) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = ACCESS;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = ACCESS;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ACCESS: begin
            err_d   = err_a;
            state_d = RESP;
         end
         RESP: begin
            // First RESP cycle lets the registered array read settle.
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = err_q;
               rsp_rdata_d = (err_q || we_q) ? '0
                  : load_extend(arr_rdata, f3_q, addr_q[1:0]);
            end else if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rdy_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         f3_q        <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= 1'b1;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         if (acc_hs) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            f3_q    <= req_funct3;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with default parameters
// (256 words, two wait states).
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   dmem_responder dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output int lat);
      @(negedge clk);
      chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = a;
      req_wdata  = wd;
      req_funct3 = f3;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("rsp_valid_after_hs", {31'b0, rsp_valid}, 32'd0);
   endtask

   task automatic xact(input string tag, input logic we,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input logic [31:0] exp_rd,
                       input logic exp_err);
      int lat;
      issue(we, a, wd, f3, lat);
      chk({tag, "_lat"}, 32'(lat), 32'd4);
      chk({tag, "_rdata"}, rsp_rdata, exp_rd);
      chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
      take();
   endtask

   initial begin
      int lat;
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_funct3 = '0;
      rsp_ready  = 1'b0;

      #12;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rel_req_ready_pre", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("rel_req_ready_post", {31'b0, req_ready}, 32'd1);

      xact("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0, 1'b0);
      xact("lw10", 1'b0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 1'b0);

      xact("sw20", 1'b1, 32'h20, 32'h0, 3'd2, 32'h0, 1'b0);
      xact("sb21", 1'b1, 32'h21, 32'hAAAAAA81, 3'd0, 32'h0, 1'b0);
      xact("lb21", 1'b0, 32'h21, 32'h0, 3'd0, 32'hFFFFFF81, 1'b0);
      xact("lbu21", 1'b0, 32'h21, 32'h0, 3'd4, 32'h00000081, 1'b0);
      xact("lw20", 1'b0, 32'h20, 32'h0, 3'd2, 32'h00008100, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
      xact("lw22", 1'b0, 32'h22, 32'h0, 3'd2, 32'h0, 1'b1);
`else
      xact("lw22", 1'b0, 32'h22, 32'h0, 3'd2, 32'h00008100, 1'b0);
`endif
      xact("lh20", 1'b0, 32'h20, 32'h0, 3'd1, 32'hFFFF8100, 1'b0);
      xact("lhu20", 1'b0, 32'h20, 32'h0, 3'd5, 32'h00008100, 1'b0);
      xact("lh22", 1'b0, 32'h22, 32'h0, 3'd1, 32'h0, 1'b0);
      xact("sh22", 1'b1, 32'h22, 32'h5A5A1234, 3'd1, 32'h0, 1'b0);
      xact("lw20_sh", 1'b0, 32'h20, 32'h0, 3'd2, 32'h12348100, 1'b0);

      xact("lf3_bad", 1'b0, 32'h10, 32'h0, 3'd3, 32'h0, 1'b1);
      xact("lf3_bad7", 1'b0, 32'h10, 32'h0, 3'd7, 32'h0, 1'b1);
      xact("sf3_bad", 1'b1, 32'h10, 32'h0, 3'd4, 32'h0, 1'b1);
      xact("lw10_kept", 1'b0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 1'b0);

      xact("sw0", 1'b1, 32'h0, 32'h01020304, 3'd2, 32'h0, 1'b0);
      xact("lw_oor", 1'b0, 32'h400, 32'h0, 3'd2, 32'h0, 1'b1);
      xact("sw_oor", 1'b1, 32'h400, 32'h11111111, 3'd2, 32'h0, 1'b1);
      xact("lw0_kept", 1'b0, 32'h0, 32'h0, 3'd2, 32'h01020304, 1'b0);
      xact("lw_last", 1'b0, 32'h3FC, 32'h0, 3'd7, 32'h0, 1'b1);

      issue(1'b0, 32'h10, 32'h0, 3'd2, lat);
      chk("bp_lat", 32'(lat), 32'd4);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
         chk("bp_err", {31'b0, rsp_err}, 32'd0);
         chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      end
      take();
      chk("bp_req_ready_after", {31'b0, req_ready}, 32'd1);

      xact("sw30", 1'b1, 32'h30, 32'hCAFEF00D, 3'd2, 32'h0, 1'b0);
      xact("lw10_pre", 1'b0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 1'b0);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_addr   = 32'h30;
      req_wdata  = 32'h00001234;
      req_funct3 = 3'd2;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_busy", {31'b0, busy}, 32'd1);
      chk("mid_rdata_held", rsp_rdata, 32'hDEADBEEF);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("mid_rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rel_req_ready", {31'b0, req_ready}, 32'd1);
      xact("lw30_after_rst", 1'b0, 32'h30, 32'h0, 3'd2, 32'hCAFEF00D, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
